// File: rtl/ring_wave_monitor.sv
// Checks period/high time of the x/y/z ring-counter outputs and reports lock/sticky errors.
// Latency: a sampled rise updates ok/err one clock later; no backpressure (pure observer).
module ring_wave_monitor #(
    parameter int CNT_W    = 8,
    parameter int X_PERIOD = 8,
    parameter int X_HIGH   = 4,
    parameter int Y_PERIOD = 8,
    parameter int Y_HIGH   = 2,
    parameter int Z_PERIOD = 6,
    parameter int Z_HIGH   = 3,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_in,
    input  logic             y_in,
    input  logic             z_in,
    input  logic             clr,
    output logic             x_ok,
    output logic             y_ok,
    output logic             z_ok,
    output logic             all_locked,
    output logic [2:0]       err_sticky,
    output logic [CNT_W-1:0] x_period
);
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam int                     GW     = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]          LOCK_V = GW'(LOCK_CNT);
    localparam logic [CNT_W-1:0]       SAT    = '1;
    // Channel index 2 = x, 1 = y, 0 = z, matching the err_sticky bit order.
    localparam logic [2:0][CNT_W-1:0]  PER_V  = {CNT_W'(X_PERIOD), CNT_W'(Y_PERIOD), CNT_W'(Z_PERIOD)};
    localparam logic [2:0][CNT_W-1:0]  HI_V   = {CNT_W'(X_HIGH), CNT_W'(Y_HIGH), CNT_W'(Z_HIGH)};

    logic [2:0]       w_in;
    logic [2:0]       r_s;
    logic [2:0]       r_sd;
    logic [2:0]       w_rise;
    logic [2:0]       w_fall;
    logic [2:0]       w_ok;
    logic [2:0]       w_err_set;
    logic [2:0]       r_err;
    logic [CNT_W-1:0] w_x_per_cnt;
    logic [CNT_W-1:0] r_x_period;

    assign w_in   = {x_in, y_in, z_in};
    assign w_rise = r_s & ~r_sd;
    assign w_fall = ~r_s & r_sd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_sd <= '0;
        end else begin
            r_s  <= w_in;
            r_sd <= r_s;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [GW-1:0]    r_good;
        logic [GW-1:0]    w_good_nxt;
        logic [GW-1:0]    w_good_inc;
        logic [CNT_W-1:0] r_per_cnt;
        logic [CNT_W-1:0] r_hi_cnt;
        logic [CNT_W-1:0] r_hi_cap;
        logic             w_match;
        logic             w_sat;
        logic             w_err;

        assign w_good_inc   = r_good + 1'b1;
        assign w_match      = (r_per_cnt == PER_V[c]) && (r_hi_cap == HI_V[c]);
        assign w_sat        = (r_per_cnt == SAT);
        assign w_ok[c]      = (r_state == LOCKED);
        assign w_err_set[c] = w_err;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_per_cnt <= '0;
                r_hi_cnt  <= '0;
                r_hi_cap  <= '0;
            end else begin
                if (w_rise[c])
                    r_per_cnt <= CNT_W'(1);
                else if (!w_sat)
                    r_per_cnt <= r_per_cnt + 1'b1;

                if (w_rise[c])
                    r_hi_cnt <= CNT_W'(1);
                else if (r_s[c] && (r_hi_cnt != SAT))
                    r_hi_cnt <= r_hi_cnt + 1'b1;

                if (w_fall[c])
                    r_hi_cap <= r_hi_cnt;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= IDLE;
                r_good  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_good  <= w_good_nxt;
            end
        end

        // A rise always takes precedence; saturation only matters when the input is stuck.
        always_comb begin
            w_state_nxt = r_state;
            w_good_nxt  = r_good;
            w_err       = 1'b0;
            if (w_rise[c]) begin
                case (r_state)
                    IDLE: begin
                        w_state_nxt = MEASURE;
                        w_good_nxt  = '0;
                    end
                    MEASURE: begin
                        if (w_match) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == LOCK_V)
                                w_state_nxt = LOCKED;
                        end else begin
                            w_good_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_match) begin
                            w_state_nxt = MEASURE;
                            w_good_nxt  = '0;
                            w_err       = 1'b1;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end else if (w_sat) begin
                w_state_nxt = IDLE;
                w_err       = (r_state == LOCKED);
            end
        end

        if (c == 2) begin : g_xper
            assign w_x_per_cnt = r_per_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= '0;
            r_x_period <= '0;
        end else begin
            r_err <= (clr ? 3'b000 : r_err) | w_err_set;
            if (w_rise[2])
                r_x_period <= w_x_per_cnt;
        end
    end

    assign x_ok       = w_ok[2];
    assign y_ok       = w_ok[1];
    assign z_ok       = w_ok[0];
    assign all_locked = &w_ok;
    assign err_sticky = r_err;
    assign x_period   = r_x_period;
endmodule

// File: tb/tb_ring_wave_monitor.sv
// Directed bench for ring_wave_monitor with a cycle-stamped expectation queue.
module tb_ring_wave_monitor;
    localparam int X = 0, Y = 1, Z = 2;
    localparam int S_XOK = 0, S_YOK = 1, S_ZOK = 2, S_ALL = 3, S_ERR = 4, S_XPER = 5;

    typedef struct {
        int          cyc;
        string       tag;
        int          sig;
        logic [15:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x_in, y_in, z_in, clr;
    logic       x_ok, y_ok, z_ok, all_locked;
    logic [2:0] err_sticky;
    logic [7:0] x_period;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   clr_edge = -1;
    int   per[3], hi[3], ph[3], en[3], hold[3];
    int   t;

    ring_wave_monitor dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .z_in(z_in), .clr(clr),
        .x_ok(x_ok), .y_ok(y_ok), .z_ok(z_ok), .all_locked(all_locked),
        .err_sticky(err_sticky), .x_period(x_period)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sample(int sig);
        case (sig)
            S_XOK:   return 16'(x_ok);
            S_YOK:   return 16'(y_ok);
            S_ZOK:   return 16'(z_ok);
            S_ALL:   return 16'(all_locked);
            S_ERR:   return 16'(err_sticky);
            S_XPER:  return 16'(x_period);
            default: return 16'hffff;
        endcase
    endfunction

    task automatic expect_at(int c, string tag, int sig, logic [15:0] v);
        exp_t e;
        e.cyc = c; e.tag = tag; e.sig = sig; e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_due();
        int i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, sample(sb[i].sig), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Values driven here are sampled by the DUT at edge cyc+1.
    task automatic drive();
        logic [2:0] v;
        v = '0;
        for (int ch = 0; ch < 3; ch++) begin
            if (en[ch] == 0) begin
                v[ch] = 1'b0;
            end else if (hold[ch] > 0) begin
                v[ch] = 1'b0;
                hold[ch]--;
            end else begin
                v[ch] = (ph[ch] < hi[ch]);
                ph[ch] = (ph[ch] + 1) % per[ch];
            end
        end
        x_in = v[X];
        y_in = v[Y];
        z_in = v[Z];
        clr  = (cyc + 1 == clr_edge);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_due();
        drive();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_ph(int ch, int p);
        int n = 0;
        while (ph[ch] != p && n < 64) begin
            tick();
            n++;
        end
        chk("sync_budget", 16'(n < 64), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; x_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
        per = '{8, 8, 6}; hi = '{4, 3, 3}; ph = '{0, 0, 0}; en = '{0, 0, 0}; hold = '{0, 0, 0};
        #3;
        chk("rst_x_ok", 16'(x_ok), 16'd0);
        chk("rst_y_ok", 16'(y_ok), 16'd0);
        chk("rst_z_ok", 16'(z_ok), 16'd0);
        chk("rst_all", 16'(all_locked), 16'd0);
        chk("rst_err", 16'(err_sticky), 16'd0);
        chk("rst_xper", 16'(x_period), 16'd0);
        run(2);
        rst_n = 1'b1;
        expect_at(cyc + 3, "idle_x_ok", S_XOK, 16'd0);
        expect_at(cyc + 3, "idle_err", S_ERR, 16'd0);
        run(4);

        // x 8/4 and z 6/3 lock; y 8/3 has the wrong high time.
        en = '{1, 1, 1};
        t = cyc + 1;
        expect_at(t + 17, "x_ok_before_lock", S_XOK, 16'd0);
        expect_at(t + 18, "x_ok_locked", S_XOK, 16'd1);
        expect_at(t + 10, "x_period_2nd", S_XPER, 16'd8);
        expect_at(t + 18, "x_period_3rd", S_XPER, 16'd8);
        expect_at(t + 13, "z_ok_before_lock", S_ZOK, 16'd0);
        expect_at(t + 14, "z_ok_locked", S_ZOK, 16'd1);
        expect_at(t + 20, "y_ok_bad_high", S_YOK, 16'd0);
        expect_at(t + 30, "y_ok_bad_high_late", S_YOK, 16'd0);
        expect_at(t + 30, "all_locked_no_y", S_ALL, 16'd0);
        expect_at(t + 30, "err_none", S_ERR, 16'd0);
        run(32);

        // z: one period of 7 loses lock, then relocks after two good periods.
        run_until_ph(Z, 4);
        hold[Z] = 1;
        t = cyc;
        expect_at(t + 5, "z_ok_before_loss", S_ZOK, 16'd1);
        expect_at(t + 6, "z_ok_lost", S_ZOK, 16'd0);
        expect_at(t + 6, "err_z_set", S_ERR, 16'b001);
        expect_at(t + 17, "z_ok_relock_pre", S_ZOK, 16'd0);
        expect_at(t + 18, "z_ok_relocked", S_ZOK, 16'd1);
        expect_at(t + 18, "err_z_sticky", S_ERR, 16'b001);
        expect_at(t + 18, "x_ok_unaffected", S_XOK, 16'd1);
        run(20);
        clr_edge = cyc + 2;
        expect_at(cyc + 1, "err_before_clr", S_ERR, 16'b001);
        expect_at(cyc + 2, "err_after_clr", S_ERR, 16'b000);
        run(4);

        // Loss and clr on the same edge: the set wins.
        run_until_ph(Z, 4);
        hold[Z] = 1;
        t = cyc;
        clr_edge = t + 6;
        expect_at(t + 6, "z_ok_lost2", S_ZOK, 16'd0);
        expect_at(t + 6, "err_set_wins", S_ERR, 16'b001);
        expect_at(t + 7, "err_set_wins_hold", S_ERR, 16'b001);
        run(20);
        clr_edge = cyc + 2;
        expect_at(cyc + 2, "err_clr_alone", S_ERR, 16'b000);
        run(4);

        // y switched to 8/2: locks, giving all_locked.
        run_until_ph(Y, 0);
        hi[Y] = 2;
        t = cyc;
        expect_at(t + 18, "y_ok_pre", S_YOK, 16'd0);
        expect_at(t + 18, "all_pre", S_ALL, 16'd0);
        expect_at(t + 19, "y_ok_locked", S_YOK, 16'd1);
        expect_at(t + 19, "all_locked", S_ALL, 16'd1);
        expect_at(t + 19, "z_ok_still", S_ZOK, 16'd1);
        run(22);

        // Mid-period async reset clears everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_x_ok", 16'(x_ok), 16'd0);
        chk("midrst_y_ok", 16'(y_ok), 16'd0);
        chk("midrst_z_ok", 16'(z_ok), 16'd0);
        chk("midrst_all", 16'(all_locked), 16'd0);
        chk("midrst_err", 16'(err_sticky), 16'd0);
        chk("midrst_xper", 16'(x_period), 16'd0);
        en = '{0, 0, 0}; ph = '{0, 0, 0}; hold = '{0, 0, 0};
        x_in = 1'b0; y_in = 1'b0; z_in = 1'b0;
        run(3);
        rst_n = 1'b1;
        en = '{1, 1, 1};
        t = cyc + 1;
        expect_at(t + 17, "rl_x_pre", S_XOK, 16'd0);
        expect_at(t + 17, "rl_y_pre", S_YOK, 16'd0);
        expect_at(t + 17, "rl_all_pre", S_ALL, 16'd0);
        expect_at(t + 13, "rl_z_pre", S_ZOK, 16'd0);
        expect_at(t + 14, "rl_z_ok", S_ZOK, 16'd1);
        expect_at(t + 18, "rl_x_ok", S_XOK, 16'd1);
        expect_at(t + 18, "rl_y_ok", S_YOK, 16'd1);
        expect_at(t + 18, "rl_all", S_ALL, 16'd1);
        expect_at(t + 18, "rl_err", S_ERR, 16'd0);
        run(32);

        // x stuck low after a rise: per counter saturates at 255 and drops lock.
        run_until_ph(X, 1);
        en[X] = 0;
        t = cyc + 1;
        expect_at(t + 1, "sat_xper", S_XPER, 16'd8);
        expect_at(t + 255, "sat_x_ok_pre", S_XOK, 16'd1);
        expect_at(t + 255, "sat_err_pre", S_ERR, 16'b000);
        expect_at(t + 256, "sat_x_ok", S_XOK, 16'd0);
        expect_at(t + 256, "sat_err", S_ERR, 16'b100);
        expect_at(t + 256, "sat_all", S_ALL, 16'd0);
        expect_at(t + 256, "sat_y_ok", S_YOK, 16'd1);
        expect_at(t + 300, "sat_x_ok_late", S_XOK, 16'd0);
        expect_at(t + 300, "sat_err_late", S_ERR, 16'b100);
        run(t + 302 - cyc);

        chk("pending_expectations", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
